// File: rtl/alu_pkg.sv
// Shared opcodes, flag layout and widths for the pipelined ALU.
package alu_pkg;
    localparam int OP_W    = 6;
    localparam int FLAGS_W = 4;

    // Bit positions inside the {C,V,Z,N} flag vector
    localparam int F_C = 3;
    localparam int F_V = 2;
    localparam int F_Z = 1;
    localparam int F_N = 0;

    localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
    localparam logic [OP_W-1:0] OP_SLL = 6'b000000;
    localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
    localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_W-1:0] OP_SLT = 6'b101010;
endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, {C,V,Z,N} flags and unsupported-opcode error.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0]  a_i,
    input  logic [DATA_W-1:0]  b_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic [SH_W-1:0]    sh_i,
    output logic [DATA_W-1:0]  res_o,
    output logic [FLAGS_W-1:0] flags_o,
    output logic               err_o
);
    localparam int MSB = DATA_W - 1;

    // One extra bit on every arithmetic/shift path captures the carry or the
    // last bit shifted out, so C falls out of the same adder/shifter.
    logic [DATA_W:0] sum, diff, sll_ext, srl_ext, sra_ext;
    logic            c, v;

    assign sum     = {1'b0, a_i} + {1'b0, b_i};
    assign diff    = {1'b0, a_i} - {1'b0, b_i};
    assign sll_ext = {1'b0, a_i} << sh_i;
    assign srl_ext = {a_i, 1'b0} >> sh_i;
    assign sra_ext = $signed({a_i, 1'b0}) >>> sh_i;

    // Select the operation result and derive the flag set from it
    always_comb begin
        res_o = '0;
        c     = 1'b0;
        v     = 1'b0;
        err_o = 1'b0;
        case (op_i)
            OP_ADD: begin
                res_o = sum[MSB:0];
                c     = sum[DATA_W];
                v     = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                res_o = diff[MSB:0];
                c     = diff[DATA_W];
                v     = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
            end
            OP_AND: res_o = a_i & b_i;
            OP_OR:  res_o = a_i | b_i;
            OP_XOR: res_o = a_i ^ b_i;
            OP_NOR: res_o = ~(a_i | b_i);
            OP_SLL: begin
                res_o = sll_ext[MSB:0];
                c     = sll_ext[DATA_W];
            end
            OP_SRL: begin
                res_o = srl_ext[DATA_W:1];
                c     = srl_ext[0];
            end
            OP_SRA: begin
                res_o = sra_ext[DATA_W:1];
                c     = sra_ext[0];
            end
            OP_SLT: res_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: err_o = 1'b1;
        endcase
        flags_o        = '0;
        flags_o[F_C]   = c;
        flags_o[F_V]   = v;
        flags_o[F_Z]   = (res_o == '0);
        flags_o[F_N]   = res_o[MSB];
    end
endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 holds operands, S2 holds the result.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [DATA_W-1:0]  i_a,
    input  logic [DATA_W-1:0]  i_b,
    input  logic [OP_W-1:0]    i_opcode,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DATA_W-1:0]  o_res,
    output logic [FLAGS_W-1:0] o_flags,
    output logic               o_err,
    output logic               o_ovf_sticky,
    input  logic               i_clr_sticky
);
    logic               s1_v_q, s2_v_q;
    logic [DATA_W-1:0]  s1_a_q, s1_b_q;
    logic [OP_W-1:0]    s1_op_q;
    logic [DATA_W-1:0]  s2_res_q, core_res;
    logic [FLAGS_W-1:0] s2_flags_q, core_flags;
    logic               s2_err_q, core_err;
    logic               sticky_q, sticky_d;
    logic               s1_en, s2_en, xfer;

    // A stage may load when it is empty or its content moves on this cycle
    assign s2_en   = ~s2_v_q | i_ready;
    assign s1_en   = ~s1_v_q | s2_en;
    assign o_ready = s1_en;
    assign xfer    = s2_v_q & i_ready;

    alu_core #(.DATA_W(DATA_W), .SH_W(SH_W)) u_core (
        .a_i     (s1_a_q),
        .b_i     (s1_b_q),
        .op_i    (s1_op_q),
        .sh_i    (s1_b_q[SH_W-1:0]),
        .res_o   (core_res),
        .flags_o (core_flags),
        .err_o   (core_err)
    );

    // Operand stage: capture a new operand set whenever S1 can advance
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_v_q  <= 1'b0;
            s1_a_q  <= '0;
            s1_b_q  <= '0;
            s1_op_q <= '0;
        end else if (s1_en) begin
            s1_v_q <= i_valid;
            if (i_valid) begin
                s1_a_q  <= i_a;
                s1_b_q  <= i_b;
                s1_op_q <= i_opcode;
            end
        end
    end

    // Result stage: hold steady under backpressure, otherwise take S1's result
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s2_v_q     <= 1'b0;
            s2_res_q   <= '0;
            s2_flags_q <= '0;
            s2_err_q   <= 1'b0;
        end else if (s2_en) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_res_q   <= core_res;
                s2_flags_q <= core_flags;
                s2_err_q   <= core_err;
            end
        end
    end

    // Sticky overflow next state: a V=1 transfer beats a same-cycle clear
    always_comb begin
        sticky_d = sticky_q;
        if (xfer && s2_flags_q[F_V]) sticky_d = 1'b1;
        else if (i_clr_sticky)       sticky_d = 1'b0;
    end

    // Sticky overflow register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) sticky_q <= 1'b0;
        else         sticky_q <= sticky_d;
    end

    assign o_valid      = s2_v_q;
    assign o_res        = s2_res_q;
    assign o_flags      = s2_flags_q;
    assign o_err        = s2_err_q;
    assign o_ovf_sticky = sticky_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Randomised + directed bench for alu_pipe with a queue-based reference model.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int DW = 8;

    logic          clk = 1'b0, rst = 1'b1;
    logic          i_valid = 1'b0, i_ready = 1'b0, i_clr_sticky = 1'b0;
    logic [DW-1:0] i_a = '0, i_b = '0;
    logic [5:0]    i_opcode = '0;
    logic          o_ready, o_valid, o_err, o_ovf_sticky;
    logic [DW-1:0] o_res;
    logic [3:0]    o_flags;

    always #5 clk = ~clk;

    alu_pipe #(.DATA_W(DW)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_opcode(i_opcode), .o_valid(o_valid),
        .i_ready(i_ready), .o_res(o_res), .o_flags(o_flags), .o_err(o_err),
        .o_ovf_sticky(o_ovf_sticky), .i_clr_sticky(i_clr_sticky)
    );

    typedef struct {
        logic [7:0] res;
        logic [3:0] flags;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    logic [7:0] out_log[$];
    int         checks = 0, failures = 0, cyc = 0, tx_cnt = 0;
    bit         acc_flag = 0, sticky_m = 0, stall_prev = 0;
    logic [7:0] prev_res, last_res;
    logic [3:0] prev_flags, last_flags;
    logic       prev_err, last_err;
    logic [5:0] ops [10] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR,
                             OP_SLL, OP_SRL, OP_SRA, OP_SLT};

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference ALU from plain integer arithmetic
    function automatic exp_t model(logic [7:0] a, logic [7:0] b, logic [5:0] op);
        exp_t m;
        int ua = int'(a), ub = int'(b);
        int sa = int'($signed(a)), sb = int'($signed(b));
        int sh = int'(b[2:0]);
        int r = 0, c = 0, v = 0, e = 0;
        case (op)
            OP_ADD: begin r = ua + ub; c = int'(r > 255);
                          v = int'((sa + sb > 127) || (sa + sb < -128)); end
            OP_SUB: begin r = ua - ub; c = int'(ua < ub);
                          v = int'((sa - sb > 127) || (sa - sb < -128)); end
            OP_AND: r = ua & ub;
            OP_OR:  r = ua | ub;
            OP_XOR: r = ua ^ ub;
            OP_NOR: r = ~(ua | ub);
            OP_SLL: begin r = ua << sh; c = (sh != 0) ? ((ua >> (8 - sh)) & 1) : 0; end
            OP_SRL: begin r = ua >> sh; c = (sh != 0) ? ((ua >> (sh - 1)) & 1) : 0; end
            OP_SRA: begin r = sa >>> sh; c = (sh != 0) ? ((sa >>> (sh - 1)) & 1) : 0; end
            OP_SLT: r = int'(sa < sb);
            default: e = 1;
        endcase
        m.res   = 8'(r & 255);
        m.flags = {c != 0, v != 0, m.res == 8'h00, m.res[7]};
        m.err   = (e != 0);
        m.cyc   = 0;
        return m;
    endfunction

    // Per-cycle comparison of DUT outputs against the model, sampled at negedge
    task automatic compare_cycle();
        bit xfer, vset, acc;
        exp_t m;
        if (rst) begin
            chk("rst_o_valid", 32'(o_valid), 0);
            chk("rst_o_res", 32'(o_res), 0);
            chk("rst_o_flags", 32'(o_flags), 0);
            chk("rst_o_err", 32'(o_err), 0);
            chk("rst_sticky", 32'(o_ovf_sticky), 0);
            q.delete();
            sticky_m = 0; stall_prev = 0; acc_flag = 0;
            cyc++;
            return;
        end
        chk("o_ready", 32'(o_ready), 32'((q.size() < 2) || i_ready));
        chk("o_valid", 32'(o_valid), 32'((q.size() > 0) && (cyc >= q[0].cyc + 2)));
        if (stall_prev && o_valid) begin
            chk("stall_res", 32'(o_res), 32'(prev_res));
            chk("stall_flags", 32'(o_flags), 32'(prev_flags));
            chk("stall_err", 32'(o_err), 32'(prev_err));
        end
        chk("sticky", 32'(o_ovf_sticky), 32'(sticky_m));
        xfer = o_valid && i_ready;
        vset = 0;
        if (xfer) begin
            if (q.size() == 0) chk("spurious_xfer", 1, 0);
            else begin
                chk("res", 32'(o_res), 32'(q[0].res));
                chk("flags", 32'(o_flags), 32'(q[0].flags));
                chk("err", 32'(o_err), 32'(q[0].err));
                vset = q[0].flags[F_V];
                void'(q.pop_front());
            end
            last_res = o_res; last_flags = o_flags; last_err = o_err;
            out_log.push_back(o_res);
            tx_cnt++;
        end
        if (xfer && vset)  sticky_m = 1;
        else if (i_clr_sticky) sticky_m = 0;
        stall_prev = o_valid && !i_ready;
        prev_res = o_res; prev_flags = o_flags; prev_err = o_err;
        acc = i_valid && o_ready;
        if (acc) begin
            m = model(i_a, i_b, i_opcode);
            m.cyc = cyc;
            q.push_back(m);
        end
        acc_flag = acc;
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [7:0] a, logic [7:0] b, logic [5:0] op);
        int k = 0;
        i_valid = 1'b1; i_a = a; i_b = b; i_opcode = op;
        do begin step(); k++; end while (!acc_flag && k < 20);
        if (!acc_flag) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_tx(int n0);
        int k = 0;
        while (tx_cnt == n0 && k < 20) begin step(); k++; end
        if (tx_cnt == n0) chk("wait_tx_timeout", 0, 1);
    endtask

    // Single operation with literal expectations for both the model and the DUT
    task automatic one(string name, logic [7:0] a, logic [7:0] b, logic [5:0] op,
                       logic [7:0] er, logic [3:0] ef, logic ee);
        int n0 = tx_cnt;
        exp_t m = model(a, b, op);
        chk({"pin_res_", name}, 32'(m.res), 32'(er));
        chk({"pin_flags_", name}, 32'(m.flags), 32'(ef));
        chk({"pin_err_", name}, 32'(m.err), 32'(ee));
        send(a, b, op);
        i_valid = 1'b0;
        wait_tx(n0);
        chk({"dut_res_", name}, 32'(last_res), 32'(er));
        chk({"dut_flags_", name}, 32'(last_flags), 32'(ef));
        chk({"dut_err_", name}, 32'(last_err), 32'(ee));
    endtask

    initial begin
        int n0, k, idx;
        repeat (3) step();
        rst = 1'b0;
        i_ready = 1'b1;
        step();

        // Directed operations, flags written {C,V,Z,N}
        one("add_ovf", 8'h7F, 8'h01, OP_ADD, 8'h80, 4'b0101, 1'b0);
        chk("add_ovf_sticky", 32'(o_ovf_sticky), 1);
        one("add_carry", 8'hFF, 8'h01, OP_ADD, 8'h00, 4'b1010, 1'b0);
        one("sub_borrow", 8'h00, 8'h01, OP_SUB, 8'hFF, 4'b1001, 1'b0);
        one("sra", 8'h81, 8'h03, OP_SRA, 8'hF0, 4'b0001, 1'b0);
        one("srl", 8'h81, 8'h03, OP_SRL, 8'h10, 4'b0000, 1'b0);
        one("sll3", 8'h81, 8'h03, OP_SLL, 8'h08, 4'b0000, 1'b0);
        one("sll1", 8'h81, 8'h01, OP_SLL, 8'h02, 4'b1000, 1'b0);
        one("slt", 8'hFE, 8'h01, OP_SLT, 8'h01, 4'b0000, 1'b0);
        one("bad_op", 8'h12, 8'h34, 6'h3F, 8'h00, 4'b0010, 1'b1);

        // Backpressure stream with i_ready low for three cycles
        out_log.delete();
        n0 = tx_cnt;
        fork
            begin
                for (int j = 0; j < 5; j++) send(8'(j), 8'h01, OP_ADD);
                i_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 i_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 i_ready = 1'b1;
            end
        join
        k = 0;
        while (tx_cnt < n0 + 5 && k < 40) begin step(); k++; end
        chk("bp_count", 32'(out_log.size()), 5);
        for (int j = 0; j < 5 && j < out_log.size(); j++)
            chk("bp_order", 32'(out_log[j]), 32'(j + 1));

        // Reset with both stages full
        i_ready = 1'b0;
        send(8'h10, 8'h01, OP_ADD);
        send(8'h20, 8'h01, OP_ADD);
        i_valid = 1'b0;
        step();
        chk("full_before_rst", 32'(o_valid), 1);
        rst = 1'b1;
        #1 chk("rst_immediate_o_valid", 32'(o_valid), 0);
        step();
        rst = 1'b0;
        i_ready = 1'b1;
        repeat (4) step();

        // Sticky: clear alone, then set beats clear, then clear alone
        i_clr_sticky = 1'b1;
        step();
        chk("sticky_cleared0", 32'(o_ovf_sticky), 0);
        n0 = tx_cnt;
        send(8'h7F, 8'h01, OP_ADD);
        i_valid = 1'b0;
        wait_tx(n0);
        chk("sticky_set_wins", 32'(o_ovf_sticky), 1);
        step();
        chk("sticky_clear_alone", 32'(o_ovf_sticky), 0);
        i_clr_sticky = 1'b0;

        // Random traffic; inputs only change once the pending set is accepted
        for (int n = 0; n < 600; n++) begin
            i_ready = ($urandom_range(0, 3) != 0);
            i_clr_sticky = ($urandom_range(0, 7) == 0);
            if (!i_valid || acc_flag) begin
                i_valid = ($urandom_range(0, 2) != 0);
                i_a = 8'($urandom);
                i_b = 8'($urandom);
                idx = $urandom_range(0, 10);
                i_opcode = (idx == 10) ? 6'($urandom) : ops[idx];
            end
            step();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_clr_sticky = 1'b0;
        repeat (5) step();
        chk("drained", 32'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
